// File: rtl/motion_exec_if.sv
// Planner-to-executor handshake: move request, per-axis direction/distance/period,
// and the completion/busy status returned to the planner.
interface motion_exec_if #(
  parameter int xy_limit  = 11,
  parameter int z_limit   = 9,
  parameter int vxy_limit = 26,
  parameter int vz_limit  = 26
);
  logic                 go;
  logic                 dirx, diry, dirz;
  logic [xy_limit-1:0]  disx, disy;
  logic [z_limit-1:0]   disz;
  logic [vxy_limit-1:0] vx, vy;
  logic [vz_limit-1:0]  vz;
  logic                 fin;
  logic                 busy;

  modport master (
    output go, dirx, diry, dirz, disx, disy, disz, vx, vy, vz,
    input  fin, busy
  );

  modport slave (
    input  go, dirx, diry, dirz, disx, disy, disz, vx, vy, vz,
    output fin, busy
  );
endinterface

// File: rtl/motion_exec.sv
// Step/dir pulse executor for three stepper axes with wrap-around position tracking.
// One motion_axis per axis; a small FSM sequences IDLE -> LOAD -> RUN -> DONE.
module motion_axis #(
  parameter int DW      = 11,
  parameter int VW      = 26,
  parameter int PULSE_W = 50
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          run,
  input  logic          dir_in,
  input  logic [DW-1:0] dis_in,
  input  logic [VW-1:0] v_in,
  output logic          step,
  output logic          dout,
  output logic [DW-1:0] pos,
  output logic          done
);
  localparam logic [VW-1:0] MIN_P  = VW'(2 * PULSE_W);
  localparam logic [VW-1:0] HIGH_W = VW'(PULSE_W);
  localparam logic [VW-1:0] ONE_V  = VW'(1);
  localparam logic [DW-1:0] ONE_D  = DW'(1);

  logic [DW-1:0] dis_reg, n_reg, n_inc;
  logic [VW-1:0] period_reg, cnt_reg, cnt_inc;

  assign cnt_inc = cnt_reg + ONE_V;
  assign n_inc   = n_reg + ONE_D;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dis_reg    <= '0;
      period_reg <= '0;
      cnt_reg    <= '0;
      n_reg      <= '0;
      pos        <= '0;
      dout       <= 1'b0;
      step       <= 1'b0;
      done       <= 1'b0;
    end else if (load) begin
      dis_reg    <= dis_in;
      period_reg <= (v_in < MIN_P) ? MIN_P : v_in;
      dout       <= dir_in;
      cnt_reg    <= '0;
      n_reg      <= '0;
      step       <= 1'b0;
      done       <= (dis_in == '0);
    end else if (run && !done) begin
      // End of a period: the pulse falls on the same edge the step is counted.
      if (cnt_reg == period_reg - ONE_V) begin
        cnt_reg <= '0;
        n_reg   <= n_inc;
        step    <= 1'b0;
        pos     <= dout ? pos + ONE_D : pos - ONE_D;
        done    <= (n_inc == dis_reg);
      end else begin
        cnt_reg <= cnt_inc;
        step    <= (cnt_inc >= period_reg - HIGH_W);
      end
    end else begin
      step <= 1'b0;
    end
  end
endmodule

module motion_exec #(
  parameter int xy_limit  = 11,
  parameter int z_limit   = 9,
  parameter int vxy_limit = 26,
  parameter int vz_limit  = 26,
  parameter int PULSE_W   = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  motion_exec_if.slave        hs,
  output logic                stepx,
  output logic                stepy,
  output logic                stepz,
  output logic                dox,
  output logic                doy,
  output logic                doz,
  output logic [xy_limit-1:0] posx,
  output logic [xy_limit-1:0] posy,
  output logic [z_limit-1:0]  posz
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t state_reg;
  logic   fin_reg, busy_reg;
  logic   load, run, done_x, done_y, done_z, all_done;

  // Dropping go mid-move stops the axes on the very edge the FSM leaves RUN.
  assign load     = (state_reg == LOAD);
  assign run      = (state_reg == RUN) && hs.go;
  assign all_done = done_x && done_y && done_z;
  assign hs.fin   = fin_reg;
  assign hs.busy  = busy_reg;

  motion_axis #(.DW(xy_limit), .VW(vxy_limit), .PULSE_W(PULSE_W)) u_axis_x (
    .clk(clk), .rst_n(rst_n), .load(load), .run(run),
    .dir_in(hs.dirx), .dis_in(hs.disx), .v_in(hs.vx),
    .step(stepx), .dout(dox), .pos(posx), .done(done_x)
  );

  motion_axis #(.DW(xy_limit), .VW(vxy_limit), .PULSE_W(PULSE_W)) u_axis_y (
    .clk(clk), .rst_n(rst_n), .load(load), .run(run),
    .dir_in(hs.diry), .dis_in(hs.disy), .v_in(hs.vy),
    .step(stepy), .dout(doy), .pos(posy), .done(done_y)
  );

  motion_axis #(.DW(z_limit), .VW(vz_limit), .PULSE_W(PULSE_W)) u_axis_z (
    .clk(clk), .rst_n(rst_n), .load(load), .run(run),
    .dir_in(hs.dirz), .dis_in(hs.disz), .v_in(hs.vz),
    .step(stepz), .dout(doz), .pos(posz), .done(done_z)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      fin_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          fin_reg <= 1'b0;
          if (hs.go) begin
            state_reg <= LOAD;
            busy_reg  <= 1'b1;
          end else begin
            busy_reg <= 1'b0;
          end
        end
        LOAD: begin
          if (!hs.go) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (!hs.go) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (all_done) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            fin_reg   <= 1'b1;
          end
        end
        DONE: begin
          // Only a go low level re-arms the FSM; fin stays up until then.
          if (!hs.go) begin
            state_reg <= IDLE;
            fin_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          fin_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/motion_exec.md
# motion_exec

Step-pulse executor on the receiving side of the judge/motion handshake. Once `go` rises, it latches the per-axis direction, distance and speed period. It then emits step/dir pulse trains for the X, Y and Z stepper drivers and asserts `fin` when every axis has completed its distance. It also keeps a wrap-around absolute step position per axis for debug and homing checks.

## Interface
Parameters:
- `xy_limit`, 11, width of X/Y distance and position
- `z_limit`, 9, width of Z distance and position
- `vxy_limit`, 26, width of X/Y period (clock cycles per step)
- `vz_limit`, 26, width of Z period
- `PULSE_W`, 50, step high time in clock cycles; minimum effective period is 2*`PULSE_W`

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `go`  in  1  level request; held high by the planner until `fin` is seen
- `dirx`, `diry`, `dirz`  in  1 each  direction (1 = positive)
- `disx`, `disy`  in  `xy_limit` each  step count for X/Y
- `disz`  in  `z_limit`  step count for Z
- `vx`, `vy`  in  `vxy_limit` each  step period for X/Y in clocks
- `vz`  in  `vz_limit`  step period for Z in clocks
- `fin`  out  1  move complete; held until `go` falls
- `busy`  out  1  high in LOAD and RUN
- `stepx`, `stepy`, `stepz`  out  1 each  step pulses to the drivers
- `dox`, `doy`, `doz`  out  1 each  latched direction outputs to the drivers
- `posx`, `posy`  out  `xy_limit` each  absolute step position
- `posz`  out  `z_limit`  absolute step position

## Operation
- Reset (`rst_n`=0 at a `clk` edge):
  - state goes to IDLE
  - all outputs go to 0, including `pos*`
  - all internal counters clear
- States:
  - IDLE:
    - `fin`=0 and `busy`=0
    - if `go`=1, go to LOAD
  - LOAD, one cycle:
    - latch `dis*` and `dir*`
    - compute P* = max(v*, 2*`PULSE_W`); v*=0 also uses the minimum
    - drive `do*` from the latched directions
    - clear the phase counters `cnt*` and step counters `n*`
    - mark axis a done if dis a = 0
    - go to RUN
  - RUN:
    - each axis runs independently
    - while not done, `cnt` counts 0..P-1 and then wraps
    - `step` = 1 while `cnt` >= P-`PULSE_W`, otherwise 0
    - when `cnt` = P-1: `n` increments and `pos` goes ±1 per `do` (modulo 2^width, wraps silently)
    - the axis is done when `n` reaches dis; its `step` is then forced 0 and `cnt` freezes
    - when all three axes are done, go to DONE
  - DONE:
    - `fin`=1, `busy`=0
    - stay until `go`=0, then go to IDLE
- Abort: `go`=0 in LOAD or RUN sends the FSM to IDLE on the next edge.
  - `step*` is forced 0 immediately (registered).
  - `pos*` keeps the steps already issued.
  - `fin` is never asserted for that move.
- `go` still high in DONE never retriggers; a new move needs `go` low for at least one cycle first.
- `dir*`, `dis*` and `v*` changing while not in LOAD have no effect.
- Arithmetic:
  - compare `n` against dis at full input width
  - `cnt` has `vxy_limit`/`vz_limit` width, so no overflow for any legal P

## Timing
- All outputs are registered.
- `go` sampled high in IDLE at edge k:
  - LOAD at k+1, `busy`=1 from k+1
  - RUN at k+2
- Step timing:
  - `do*` is valid from k+2, at least P-`PULSE_W` ≥ `PULSE_W` cycles before the first `step` rise (direction setup)
  - the first rising `step` occurs P-`PULSE_W` cycles into RUN
  - each pulse is exactly `PULSE_W` cycles high
  - step periods are exactly P
- Completion:
  - the last axis's final pulse falls at the edge where its `n` = dis
  - `fin` rises on the following edge
  - `fin` falls on the edge after `go` is sampled 0
- The planner samples `fin` on a slower clock; `fin` is level-held for any length until `go` is removed.
- A zero-distance move (all dis = 0) gives `fin` at k+3.

## Test plan
- Reset: drive `rst_n`=0 mid-RUN with `disx`=10 → next cycle all `step*`=0, `fin`=0, `busy`=0, `pos*`=0, state IDLE.
- Single axis:
  - stimulus: `disx`=5, `vx`=200, `dirx`=1, `disy`=`disz`=0, `go`=1
  - response: exactly 5 `stepx` pulses, each 50 cycles high, period 200, first rise 150 cycles after RUN entry
  - response: `posx`=5; `fin` one cycle after the 5th fall, held until `go`=0
- Three axes:
  - stimulus: `disx`=3/`vx`=300, `disy`=6/`vy`=150, `disz`=2/`vz`=450, with `diry`=0
  - response: all finish at 900 cycles; `posy` = 2^11-6 (wrap); `fin` rises exactly once
- Clamp: `vx`=0 and `vx`=30 with `disx`=4 → period 100 in both cases, 4 pulses.
- Abort: drop `go` after the 2nd `stepx` pulse of a 10-step move → `stepx` low next cycle, `posx`=2, no `fin`; a new `go` starts cleanly from LOAD.
- Zero move: all dis = 0 with `go`=1 → no pulses, `fin` at k+3; holding `go` high does not retrigger.
